mem_access: RTL and testbench

- MEM stage placed directly downstream of EX.
- Latches EX results into its own stage register and runs the Dcache load/store handshake.
- Aligns store data and extracts/extends load data.
- Stalls the pipeline through fc while a Dcache access is outstanding; passes register-file and CSR writeback fields to MEM/WB.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_lsu_align.sv | 60 ++++++
 rtl/mem_access.sv | 125 ++++++++++++
 tb/tb_mem_access.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: access widths, load/store flag,
// FSM states, the stage-register layout and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] MEM_BYTE  = 2'b00;
  localparam logic [1:0] MEM_HALF  = 2'b01;
  localparam logic [1:0] MEM_WORD  = 2'b10;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] reg_wdata;
    logic [4:0]  reg_waddr;
    logic        reg_we;
    logic [31:0] csr_wdata;
    logic [11:0] csr_waddr;
    logic        csr_we;
    logic        mtype;
    logic        mem_rw;
    logic [1:0]  mem_width;
    logic        mem_rdtype;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
  } stage_t;

  // Width code 11 is handled as a word access.
  function automatic logic mem_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    case (width)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic for the MEM stage: store strobes and lane replication,
// load lane extraction with sign/zero extension, and misalign detection.
module mem_lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_rdtype,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_misalign = mem_misaligned(i_width, i_addr_lo);

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wr_data;
    case (i_width)
      MEM_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wr_data[7:0]}};
      end
      MEM_HALF: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: ;
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // rdtype 1 selects zero extension.
  always_comb begin
    o_ld_data = i_rdata;
    case (i_width)
      MEM_BYTE: o_ld_data = {{24{w_byte[7] & ~i_rdtype}}, w_byte};
      MEM_HALF: o_ld_data = {{16{w_half[15] & ~i_rdtype}}, w_half};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: latches EX results, runs the Dcache handshake and stalls the
// pipeline while an access is outstanding.
//   state   | meaning
//   ST_IDLE | stage holds a non-memory op or a finished/faulted memory op
//   ST_REQ  | Dcache request outstanding, pipeline frozen
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ex_reg_wdata_i,
  input  logic [4:0]      ex_reg_waddr_i,
  input  logic            ex_reg_we_i,
  input  logic [XLEN-1:0] ex_csr_wdata_i,
  input  logic [11:0]     ex_csr_waddr_i,
  input  logic            ex_csr_we_i,
  input  logic            ex_mtype_i,
  input  logic            ex_mem_rw_i,
  input  logic [1:0]      ex_mem_width_i,
  input  logic            ex_mem_rdtype_i,
  input  logic [XLEN-1:0] ex_mem_addr_i,
  input  logic [XLEN-1:0] ex_mem_wr_data_i,
  output logic            mem_dcache_req_o,
  output logic            mem_dcache_we_o,
  output logic [XLEN-1:0] mem_dcache_addr_o,
  output logic [3:0]      mem_dcache_wstrb_o,
  output logic [XLEN-1:0] mem_dcache_wdata_o,
  input  logic            dcache_ack_i,
  input  logic [XLEN-1:0] dcache_rdata_i,
  output logic            mem_stall_o,
  output logic            mem_misalign_o,
  output logic [XLEN-1:0] mem_reg_wdata_o,
  output logic [4:0]      mem_reg_waddr_o,
  output logic            mem_reg_we_o,
  output logic [XLEN-1:0] mem_csr_wdata_o,
  output logic [11:0]     mem_csr_waddr_o,
  output logic            mem_csr_we_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  stage_t      r_s;
  stage_t      w_ex;
  logic [31:0] r_ld_data;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_ext;
  logic        w_align_err;
  logic        w_in_req;
  logic        w_misalign;
  logic        w_is_load;
  logic        w_is_store;

  assign w_ex = '{reg_wdata:   ex_reg_wdata_i,
                  reg_waddr:   ex_reg_waddr_i,
                  reg_we:      ex_reg_we_i,
                  csr_wdata:   ex_csr_wdata_i,
                  csr_waddr:   ex_csr_waddr_i,
                  csr_we:      ex_csr_we_i,
                  mtype:       ex_mtype_i,
                  mem_rw:      ex_mem_rw_i,
                  mem_width:   ex_mem_width_i,
                  mem_rdtype:  ex_mem_rdtype_i,
                  mem_addr:    ex_mem_addr_i,
                  mem_wr_data: ex_mem_wr_data_i};

  mem_lsu_align u_align (
    .i_width    (r_s.mem_width),
    .i_addr_lo  (r_s.mem_addr[1:0]),
    .i_rdtype   (r_s.mem_rdtype),
    .i_wr_data  (r_s.mem_wr_data),
    .i_rdata    (dcache_rdata_i),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_ld_data  (w_ld_ext),
    .o_misalign (w_align_err)
  );

  assign w_in_req   = (r_state == ST_REQ);
  assign w_misalign = r_s.mtype & w_align_err;
  assign w_is_load  = r_s.mtype & (r_s.mem_rw == MEM_LOAD);
  assign w_is_store = r_s.mtype & (r_s.mem_rw == MEM_STORE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_ld_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_in_req) r_s <= w_ex;
      if (w_in_req && dcache_ack_i && w_is_load) r_ld_data <= w_ld_ext;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ex_mtype_i && !mem_misaligned(ex_mem_width_i, ex_mem_addr_i[1:0]))
                 w_state_nxt = ST_REQ;
      ST_REQ:  if (dcache_ack_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dcache signals are gated so a bubble stage shows an all-zero bus.
  assign mem_dcache_req_o   = w_in_req;
  assign mem_dcache_we_o    = w_in_req & r_s.mem_rw;
  assign mem_dcache_addr_o  = w_in_req ? {r_s.mem_addr[31:2], 2'b00} : '0;
  assign mem_dcache_wstrb_o = w_in_req ? w_wstrb : 4'b0000;
  assign mem_dcache_wdata_o = w_in_req ? w_wdata : '0;

  assign mem_stall_o    = w_in_req;
  assign mem_misalign_o = w_misalign;

  assign mem_reg_wdata_o = w_is_load ? r_ld_data : r_s.reg_wdata;
  assign mem_reg_waddr_o = r_s.reg_waddr;
  assign mem_reg_we_o    = ~w_in_req & r_s.reg_we & ~w_is_store & ~w_misalign;
  assign mem_csr_wdata_o = r_s.csr_wdata;
  assign mem_csr_waddr_o = r_s.csr_waddr;
  assign mem_csr_we_o    = ~w_in_req & r_s.csr_we & ~w_misalign;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU passthrough, loads/stores with
// various stall lengths, misalignment, back-to-back ops and reset abort.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ex_reg_wdata_i;
  logic [4:0]  ex_reg_waddr_i;
  logic        ex_reg_we_i;
  logic [31:0] ex_csr_wdata_i;
  logic [11:0] ex_csr_waddr_i;
  logic        ex_csr_we_i;
  logic        ex_mtype_i;
  logic        ex_mem_rw_i;
  logic [1:0]  ex_mem_width_i;
  logic        ex_mem_rdtype_i;
  logic [31:0] ex_mem_addr_i;
  logic [31:0] ex_mem_wr_data_i;
  logic        mem_dcache_req_o;
  logic        mem_dcache_we_o;
  logic [31:0] mem_dcache_addr_o;
  logic [3:0]  mem_dcache_wstrb_o;
  logic [31:0] mem_dcache_wdata_o;
  logic        dcache_ack_i;
  logic [31:0] dcache_rdata_i;
  logic        mem_stall_o;
  logic        mem_misalign_o;
  logic [31:0] mem_reg_wdata_o;
  logic [4:0]  mem_reg_waddr_o;
  logic        mem_reg_we_o;
  logic [31:0] mem_csr_wdata_o;
  logic [11:0] mem_csr_waddr_o;
  logic        mem_csr_we_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_reg_wdata_i     (ex_reg_wdata_i),
    .ex_reg_waddr_i     (ex_reg_waddr_i),
    .ex_reg_we_i        (ex_reg_we_i),
    .ex_csr_wdata_i     (ex_csr_wdata_i),
    .ex_csr_waddr_i     (ex_csr_waddr_i),
    .ex_csr_we_i        (ex_csr_we_i),
    .ex_mtype_i         (ex_mtype_i),
    .ex_mem_rw_i        (ex_mem_rw_i),
    .ex_mem_width_i     (ex_mem_width_i),
    .ex_mem_rdtype_i    (ex_mem_rdtype_i),
    .ex_mem_addr_i      (ex_mem_addr_i),
    .ex_mem_wr_data_i   (ex_mem_wr_data_i),
    .mem_dcache_req_o   (mem_dcache_req_o),
    .mem_dcache_we_o    (mem_dcache_we_o),
    .mem_dcache_addr_o  (mem_dcache_addr_o),
    .mem_dcache_wstrb_o (mem_dcache_wstrb_o),
    .mem_dcache_wdata_o (mem_dcache_wdata_o),
    .dcache_ack_i       (dcache_ack_i),
    .dcache_rdata_i     (dcache_rdata_i),
    .mem_stall_o        (mem_stall_o),
    .mem_misalign_o     (mem_misalign_o),
    .mem_reg_wdata_o    (mem_reg_wdata_o),
    .mem_reg_waddr_o    (mem_reg_waddr_o),
    .mem_reg_we_o       (mem_reg_we_o),
    .mem_csr_wdata_o    (mem_csr_wdata_o),
    .mem_csr_waddr_o    (mem_csr_waddr_o),
    .mem_csr_we_o       (mem_csr_we_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_reg_wdata_i   = '0; ex_reg_waddr_i = '0; ex_reg_we_i = 1'b0;
    ex_csr_wdata_i   = '0; ex_csr_waddr_i = '0; ex_csr_we_i = 1'b0;
    ex_mtype_i       = 1'b0; ex_mem_rw_i = 1'b0; ex_mem_width_i = 2'b00;
    ex_mem_rdtype_i  = 1'b0; ex_mem_addr_i = '0; ex_mem_wr_data_i = '0;
  endtask

  task automatic mem_op(input logic rw, input logic [1:0] width, input logic rdtype,
                        input logic [31:0] addr, input logic [31:0] wr_data,
                        input logic [4:0] rd);
    bubble();
    ex_mtype_i = 1'b1; ex_mem_rw_i = rw; ex_mem_width_i = width;
    ex_mem_rdtype_i = rdtype; ex_mem_addr_i = addr; ex_mem_wr_data_i = wr_data;
    ex_reg_waddr_i = rd; ex_reg_we_i = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req"},    {31'd0, mem_dcache_req_o}, 32'd0);
    chk({tag, " stall"},  {31'd0, mem_stall_o}, 32'd0);
    chk({tag, " addr"},   mem_dcache_addr_o, 32'd0);
    chk({tag, " wstrb"},  {28'd0, mem_dcache_wstrb_o}, 32'd0);
    chk({tag, " wdata"},  mem_dcache_wdata_o, 32'd0);
    chk({tag, " dwe"},    {31'd0, mem_dcache_we_o}, 32'd0);
    chk({tag, " mis"},    {31'd0, mem_misalign_o}, 32'd0);
    chk({tag, " reg_we"}, {31'd0, mem_reg_we_o}, 32'd0);
    chk({tag, " reg_wd"}, mem_reg_wdata_o, 32'd0);
    chk({tag, " reg_wa"}, {27'd0, mem_reg_waddr_o}, 32'd0);
    chk({tag, " csr_we"}, {31'd0, mem_csr_we_o}, 32'd0);
    chk({tag, " csr_wd"}, mem_csr_wdata_o, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    dcache_ack_i = 1'b0;
    dcache_rdata_i = '0;
    bubble();
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ALU result to x5
    ex_reg_wdata_i = 32'h1234; ex_reg_waddr_i = 5'd5; ex_reg_we_i = 1'b1;
    step();
    chk("add we",    {31'd0, mem_reg_we_o}, 32'd1);
    chk("add waddr", {27'd0, mem_reg_waddr_o}, 32'd5);
    chk("add wdata", mem_reg_wdata_o, 32'h1234);
    chk("add req",   {31'd0, mem_dcache_req_o}, 32'd0);
    chk("add stall", {31'd0, mem_stall_o}, 32'd0);

    // CSR write passthrough
    bubble();
    ex_csr_wdata_i = 32'hABCD_0001; ex_csr_waddr_i = 12'h300; ex_csr_we_i = 1'b1;
    step();
    chk("csr we",    {31'd0, mem_csr_we_o}, 32'd1);
    chk("csr waddr", {20'd0, mem_csr_waddr_o}, 32'h300);
    chk("csr wdata", mem_csr_wdata_o, 32'hABCD_0001);
    chk("csr regwe", {31'd0, mem_reg_we_o}, 32'd0);

    // LB signed at 0x103, ack in third REQ cycle
    mem_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6);
    step();
    bubble();
    ex_reg_wdata_i = 32'h7777; ex_reg_waddr_i = 5'd9; ex_reg_we_i = 1'b1;
    chk("lb stall1", {31'd0, mem_stall_o}, 32'd1);
    chk("lb req1",   {31'd0, mem_dcache_req_o}, 32'd1);
    chk("lb addr1",  mem_dcache_addr_o, 32'h100);
    chk("lb dwe1",   {31'd0, mem_dcache_we_o}, 32'd0);
    chk("lb regwe1", {31'd0, mem_reg_we_o}, 32'd0);
    step();
    chk("lb stall2", {31'd0, mem_stall_o}, 32'd1);
    chk("lb addr2",  mem_dcache_addr_o, 32'h100);
    step();
    chk("lb stall3", {31'd0, mem_stall_o}, 32'd1);
    chk("lb addr3",  mem_dcache_addr_o, 32'h100);
    dcache_ack_i = 1'b1; dcache_rdata_i = 32'h80AA_BBCC;
    step();
    dcache_ack_i = 1'b0; dcache_rdata_i = 32'h0;
    chk("lb stall_end", {31'd0, mem_stall_o}, 32'd0);
    chk("lb req_end",   {31'd0, mem_dcache_req_o}, 32'd0);
    chk("lb we",        {31'd0, mem_reg_we_o}, 32'd1);
    chk("lb waddr",     {27'd0, mem_reg_waddr_o}, 32'd6);
    chk("lb wdata",     mem_reg_wdata_o, 32'hFFFF_FF80);

    // LHU at 0x102, immediate ack
    mem_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd7);
    step();
    bubble();
    chk("lhu stall", {31'd0, mem_stall_o}, 32'd1);
    chk("lhu addr",  mem_dcache_addr_o, 32'h100);
    dcache_ack_i = 1'b1; dcache_rdata_i = 32'h8001_7FFF;
    step();
    dcache_ack_i = 1'b0; dcache_rdata_i = 32'h0;
    chk("lhu stall_end", {31'd0, mem_stall_o}, 32'd0);
    chk("lhu we",        {31'd0, mem_reg_we_o}, 32'd1);
    chk("lhu wdata",     mem_reg_wdata_o, 32'h0000_8001);

    // SB 0x5A at 0x201 with junk in the upper store bits
    mem_op(1'b1, 2'b00, 1'b0, 32'h201, 32'hDEAD_BE5A, 5'd3);
    step();
    bubble();
    chk("sb req",   {31'd0, mem_dcache_req_o}, 32'd1);
    chk("sb dwe",   {31'd0, mem_dcache_we_o}, 32'd1);
    chk("sb addr",  mem_dcache_addr_o, 32'h200);
    chk("sb wstrb", {28'd0, mem_dcache_wstrb_o}, 32'h2);
    chk("sb wdata", mem_dcache_wdata_o, 32'h5A5A_5A5A);
    dcache_ack_i = 1'b1;
    step();
    dcache_ack_i = 1'b0;
    chk("sb stall_end", {31'd0, mem_stall_o}, 32'd0);
    chk("sb regwe",     {31'd0, mem_reg_we_o}, 32'd0);

    // SH at 0x202: upper half lane
    mem_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h1111_BEEF, 5'd3);
    step();
    bubble();
    chk("sh wstrb", {28'd0, mem_dcache_wstrb_o}, 32'hC);
    chk("sh wdata", mem_dcache_wdata_o, 32'hBEEF_BEEF);
    dcache_ack_i = 1'b1;
    step();
    dcache_ack_i = 1'b0;

    // SW misaligned at 0x206
    mem_op(1'b1, 2'b10, 1'b0, 32'h206, 32'h1234_5678, 5'd3);
    ex_csr_we_i = 1'b1; ex_csr_waddr_i = 12'h305;
    step();
    bubble();
    chk("sw mis",    {31'd0, mem_misalign_o}, 32'd1);
    chk("sw req",    {31'd0, mem_dcache_req_o}, 32'd0);
    chk("sw stall",  {31'd0, mem_stall_o}, 32'd0);
    chk("sw regwe",  {31'd0, mem_reg_we_o}, 32'd0);
    chk("sw csrwe",  {31'd0, mem_csr_we_o}, 32'd0);
    step();
    chk("sw mis_clr", {31'd0, mem_misalign_o}, 32'd0);

    // LW then ADD; ADD must wait behind the stall
    mem_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd8);
    step();
    bubble();
    ex_reg_wdata_i = 32'h55; ex_reg_waddr_i = 5'd9; ex_reg_we_i = 1'b1;
    chk("lw stall1", {31'd0, mem_stall_o}, 32'd1);
    chk("lw wstrb",  {28'd0, mem_dcache_wstrb_o}, 32'hF);
    step();
    chk("lw stall2", {31'd0, mem_stall_o}, 32'd1);
    chk("lw waddr_hold", {27'd0, mem_reg_waddr_o}, 32'd8);
    dcache_ack_i = 1'b1; dcache_rdata_i = 32'hCAFE_F00D;
    step();
    dcache_ack_i = 1'b0; dcache_rdata_i = 32'h0;
    chk("lw waddr", {27'd0, mem_reg_waddr_o}, 32'd8);
    chk("lw wdata", mem_reg_wdata_o, 32'hCAFE_F00D);
    chk("lw we",    {31'd0, mem_reg_we_o}, 32'd1);
    step();
    bubble();
    chk("add2 waddr", {27'd0, mem_reg_waddr_o}, 32'd9);
    chk("add2 wdata", mem_reg_wdata_o, 32'h55);
    chk("add2 we",    {31'd0, mem_reg_we_o}, 32'd1);

    // Reset while a request is outstanding
    mem_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd10);
    step();
    chk("rst pre_req", {31'd0, mem_dcache_req_o}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_all_zero("rst_req");
    rst_n = 1'b1;
    bubble();
    step();
    chk("rst post_stall", {31'd0, mem_stall_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
